// File: rtl/ballot_pkg.sv
// ballot_pkg: shared state, candidate types and helpers for the ballot front end
package ballot_pkg;
  localparam int NUM_CAND = 3;
  typedef enum logic [1:0] {IDLE, PREARM, ARMED, CAST} state_t;
  typedef enum logic [1:0] {CAND_A, CAND_B, CAND_C} cand_t;
  function automatic logic [1:0] count_ones(input logic [NUM_CAND-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and registered rising-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      level_q <= level;
      rise <= level & ~level_q;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        level <= ~level;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ballot_controller.sv
// ballot_controller: debounced one-vote-per-ballot front end; BALLOT_TIMEOUT_EN adds open-ballot expiry
module ballot_controller
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int VOTER_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_A,
  input  logic btn_B,
  input  logic btn_C,
  input  logic btn_issue,
  output logic vote_A,
  output logic vote_B,
  output logic vote_C,
  output logic ready,
  output logic invalid,
  output logic timeout,
  output logic [VOTER_W-1:0] voters_served
);
  localparam int ISSUE = NUM_CAND;
  logic [NUM_CAND:0] raw, lvl, rise;
  logic [NUM_CAND-1:0] cl, cr;
  logic [1:0] pop;
  state_t state, state_n;
  cand_t cand, cand_n;
  logic invalid_n, timeout_n, expire, unused_issue;
  assign raw = {btn_issue, btn_C, btn_B, btn_A};
  for (genvar b = 0; b <= NUM_CAND; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .btn(raw[b]), .level(lvl[b]), .rise(rise[b])
    );
  end
  assign cl = lvl[NUM_CAND-1:0];
  assign cr = rise[NUM_CAND-1:0];
  assign pop = count_ones(cl);
  assign unused_issue = lvl[ISSUE];
`ifdef BALLOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) tcnt <= '0;
    else tcnt <= tcnt + TW'(1);
  end
  assign expire = (state == PREARM || state == ARMED) && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cand_n = cand;
    invalid_n = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: state_n = rise[ISSUE] ? PREARM : IDLE;
      PREARM: begin
        timeout_n = expire;
        state_n = expire ? IDLE : (cl == '0) ? ARMED : PREARM;
      end
      ARMED: begin
        // a valid vote wins over expiry arriving in the same cycle
        if (|cr && pop == 2'd1) begin
          state_n = CAST;
          cand_n = cl[0] ? CAND_A : cl[1] ? CAND_B : CAND_C;
        end else if (expire) begin
          state_n = IDLE;
          timeout_n = 1'b1;
        end else if (|cr && pop > 2'd1) begin
          state_n = PREARM;
          invalid_n = 1'b1;
        end
      end
      CAST: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cand <= CAND_A;
      invalid <= 1'b0;
      timeout <= 1'b0;
      voters_served <= '0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      invalid <= invalid_n;
      timeout <= timeout_n;
      if (state == CAST && !(&voters_served)) voters_served <= voters_served + VOTER_W'(1);
    end
  end
  assign ready = state == ARMED;
  assign vote_A = state == CAST && cand == CAND_A && !reset;
  assign vote_B = state == CAST && cand == CAND_B && !reset;
  assign vote_C = state == CAST && cand == CAND_C && !reset;
endmodule

// File: tb/tb_ballot_controller.sv
// tb_ballot_controller: randomized self-checking bench for ballot_controller
module tb_ballot_controller;
  localparam int D = 4;
  localparam int VW = 8;
  localparam int SAT = (1 << VW) - 1;
  logic clk = 0, reset = 1, btn_A = 0, btn_B = 0, btn_C = 0, btn_issue = 0;
  logic vote_A, vote_B, vote_C, ready, invalid, timeout;
  logic [VW-1:0] voters_served;
  int total = 0, bad = 0;
  int na = 0, nb = 0, nc = 0, ninv = 0, nto = 0, nexcl = 0;
  int ea = 0, eb = 0, ec = 0, einv = 0, served = 0;

  ballot_controller #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(64), .VOTER_W(VW)) dut (
    .clk(clk), .reset(reset), .btn_A(btn_A), .btn_B(btn_B), .btn_C(btn_C),
    .btn_issue(btn_issue), .vote_A(vote_A), .vote_B(vote_B), .vote_C(vote_C),
    .ready(ready), .invalid(invalid), .timeout(timeout), .voters_served(voters_served)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    na <= na + int'(vote_A);
    nb <= nb + int'(vote_B);
    nc <= nc + int'(vote_C);
    ninv <= ninv + int'(invalid);
    nto <= nto + int'(timeout);
    if (int'(vote_A) + int'(vote_B) + int'(vote_C) > 1 || (ready && (vote_A || vote_B || vote_C)))
      nexcl <= nexcl + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    {btn_C, btn_B, btn_A} = m;
    tick(hold);
    {btn_C, btn_B, btn_A} = 3'b000;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(3);
    reset = 0;
    served = 0;
  endtask

  task automatic open_ballot(output bit ok);
    btn_issue = 1;
    tick(8);
    btn_issue = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ready) ok = 1;
      else tick();
    end
  endtask

  task automatic check_counts(input string name);
    total++;
    if (na !== ea || nb !== eb || nc !== ec || ninv !== einv) begin
      bad++;
      $display("FAIL %s votes got A=%0d B=%0d C=%0d inv=%0d exp A=%0d B=%0d C=%0d inv=%0d",
               name, na, nb, nc, ninv, ea, eb, ec, einv);
    end
    total++;
    if (voters_served !== VW'(served)) begin
      bad++;
      $display("FAIL %s voters_served got=%0d exp=%0d", name, voters_served, served);
    end
  endtask

  task automatic check_open(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s ready got=0 exp=1 within bound", name);
    end
  endtask

  task automatic test_reset();
    int rdy = 0;
    do_reset();
    tick(20);
    total++;
    if ({vote_A, vote_B, vote_C, ready, invalid, timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=000000", {vote_A, vote_B, vote_C, ready, invalid, timeout});
    end
    btn_B = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      rdy += int'(ready);
    end
    btn_B = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rdy += int'(ready);
    end
    total++;
    if (rdy !== 0) begin
      bad++;
      $display("FAIL idle_ready got=%0d cycles exp=0", rdy);
    end
    check_counts("idle_press");
  endtask

  task automatic test_single_vote();
    bit ok;
    int hits = 0, at = -1;
    open_ballot(ok);
    check_open("single_open", ok);
    btn_A = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 10) btn_A = 0;
      if (vote_A) begin
        hits++;
        at = k;
      end
    end
    ea++;
    served++;
    total++;
    if (hits !== 1 || at !== 1 + D + 3) begin
      bad++;
      $display("FAIL vote_latency got hits=%0d at=%0d exp hits=1 at=%0d", hits, at, 1 + D + 3);
    end
    tick(4);
    check_counts("single_vote");
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_cast got=%b exp=0", ready);
    end
    press(3'b001, 10);
    tick(12);
    check_counts("repress_after_cast");
  endtask

  task automatic test_invalid();
    bit ok;
    open_ballot(ok);
    check_open("invalid_open", ok);
    press(3'b101, 10);
    tick(4);
    einv++;
    check_counts("double_press");
    tick(10);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ready) ok = 1;
      else tick();
    end
    check_open("rearm_after_invalid", ok);
    press(3'b100, 8);
    tick(8);
    ec++;
    served++;
    check_counts("retry_vote_C");
  endtask

  task automatic test_glitch_and_held();
    bit ok;
    int rdy = 0;
    open_ballot(ok);
    check_open("glitch_open", ok);
    press(3'b010, D - 1);
    tick(15);
    check_counts("glitch_B");
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_glitch got=%b exp=1", ready);
    end
    press(3'b010, 8);
    tick(8);
    eb++;
    served++;
    check_counts("vote_B_after_glitch");
    btn_A = 1;
    tick(10);
    btn_issue = 1;
    tick(8);
    btn_issue = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rdy += int'(ready);
    end
    total++;
    if (rdy !== 0) begin
      bad++;
      $display("FAIL held_blocks_ready got=%0d cycles exp=0", rdy);
    end
    check_counts("held_before_issue");
    btn_A = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (ready) ok = 1;
      else tick();
    end
    check_open("arm_after_release", ok);
    press(3'b001, 7);
    tick(8);
    ea++;
    served++;
    check_counts("vote_after_release");
  endtask

  task automatic test_saturation();
    bit ok;
    int c;
    do_reset();
    for (int n = 0; n < 260; n++) begin
      open_ballot(ok);
      check_open("sat_open", ok);
      if ($urandom_range(0, 1) == 1) begin
        press(3'($urandom_range(1, 7)), $urandom_range(1, D - 1));
        tick(D + 3);
      end
      c = $urandom_range(0, 2);
      press(3'(1 << c), $urandom_range(D + 1, 12));
      tick(8);
      if (c == 0) ea++;
      else if (c == 1) eb++;
      else ec++;
      served = (served < SAT) ? served + 1 : SAT;
      total++;
      if (voters_served !== VW'(served)) begin
        bad++;
        $display("FAIL sat_served ballot=%0d got=%0d exp=%0d", n, voters_served, served);
      end
    end
    check_counts("saturation_end");
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int r = 5; r <= 7; r++) begin
      open_ballot(ok);
      check_open("reset_mid_open", ok);
      btn_A = 1;
      tick(r);
      reset = 1;
      tick(2);
      btn_A = 0;
      reset = 0;
      served = 0;
      tick(12);
      check_counts("reset_mid");
    end
    total++;
    if (nexcl !== 0) begin
      bad++;
      $display("FAIL exclusivity got=%0d bad cycles exp=0", nexcl);
    end
  endtask

  task automatic test_timeout();
    bit ok, seen;
    int miss = 0;
    open_ballot(ok);
    check_open("timeout_open", ok);
`ifdef BALLOT_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (timeout) seen = 1;
    end
    total++;
    if (!seen || ready !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse got seen=%0d ready=%b exp seen=1 ready=0", seen, ready);
    end
    press(3'b001, 10);
    tick(10);
    check_counts("press_after_timeout");
`else
    seen = 0;
    for (int i = 0; i < 210; i++) begin
      tick();
      miss += int'(!ready);
      if (timeout) seen = 1;
    end
    total++;
    if (miss !== 0 || seen !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout got not_ready=%0d timeout=%0d exp 0 0", miss, seen);
    end
    press(3'b100, 8);
    tick(8);
    ec++;
    served++;
    check_counts("vote_after_long_wait");
`endif
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_invalid();
    test_glitch_and_held();
    test_saturation();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
Front-end ballot unit that feeds the vote-counting stage. Synchronises and debounces the three candidate buttons and the presiding officer's "issue ballot" button, and enforces one vote per issued ballot. Emits single-cycle vote_A/vote_B/vote_C pulses that connect directly to the counter's vote inputs. Also keeps a voters-served tally used to cross-check the candidate totals.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required before a debounced level changes (must be >= 1)
TIMEOUT_CYCLES, 64, cycles a ballot may stay open before it is cancelled (used only with the optional feature)
VOTER_W, 8, width of voters_served

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
btn_A  input  1  raw candidate A button, asynchronous, active-high
btn_B  input  1  raw candidate B button
btn_C  input  1  raw candidate C button
btn_issue  input  1  raw officer "issue ballot" button
vote_A  output  1  one-cycle pulse: one vote cast for A
vote_B  output  1  one-cycle pulse: one vote cast for B
vote_C  output  1  one-cycle pulse: one vote cast for C
ready  output  1  ballot open and voter may press (ARMED)
invalid  output  1  one-cycle pulse: multiple candidates pressed together
timeout  output  1  one-cycle pulse: open ballot cancelled (always 0 without the optional feature)
voters_served  output  VOTER_W  ballots successfully cast, saturating

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. No asynchronous reset anywhere.
- Reset clears all sync flops, debounce counters and debounced levels to 0, and sets the FSM to IDLE. All outputs are 0 and voters_served is 0 on the cycle after reset is sampled.
- Reset mid-operation aborts any open ballot. No vote pulse is emitted on or after the reset cycle.
- Input path per button: 2-flop synchroniser, then debouncer. The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it. A rising-edge detector follows the debouncer.
- Latency: a raw button held steady produces its debounced rising edge a fixed L = DEBOUNCE_CYCLES+2 cycles after first sampling. The resulting vote pulse is registered one cycle later, at L+1. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- FSM states: IDLE, PREARM, ARMED, CAST.
- IDLE:
  - issue edge -> PREARM.
  - Candidate edges are ignored.
- PREARM:
  - Waits until all three candidate debounced levels are 0, then -> ARMED. This blocks buttons held before the ballot was issued.
- ARMED:
  - ready=1.
  - On a cycle with any candidate rising edge, count the debounced candidate levels that are 1.
  - Exactly one is 1 -> CAST, latching that candidate.
  - More than one is 1 (simultaneous or overlapping press) -> invalid pulse for 1 cycle, no vote, -> PREARM. The same voter retries after releasing all buttons.
- CAST:
  - For exactly one cycle, assert the latched candidate's vote pulse.
  - voters_served += 1, saturating at all-ones (no wrap).
  - Then -> IDLE.
- issue edges in PREARM, ARMED or CAST are ignored; they do not extend or restart the ballot.
- At most one vote_* output is high in any cycle, and there is at most one vote pulse per issue edge.
- ready is high only in ARMED. ready and vote pulses are never high in the same cycle.

Optional Feature:
- Macro: BALLOT_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in PREARM or ARMED and clears on entering either state from IDLE.
  - When it reaches TIMEOUT_CYCLES: timeout pulse for 1 cycle, -> IDLE, no vote.
  - A candidate edge and expiry in the same cycle: the vote wins.
- Not defined:
  - No counter logic is present, timeout is tied to 0, and a ballot stays open indefinitely.

Decomposition:
- Shared package ballot_pkg holds:
  - the FSM state enum (IDLE, PREARM, ARMED, CAST);
  - a candidate index type (CAND_A, CAND_B, CAND_C);
  - NUM_CAND = 3.
- One natural sub-module: btn_debounce (synchroniser + debounce counter + rising-edge output, parameter DEBOUNCE_CYCLES). It is instantiated four times.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, voters_served=0. Press btn_B in IDLE without issue -> no vote_B, ready stays 0.
- Issue, then btn_A held 10 cycles (DEBOUNCE_CYCLES=4) -> ready=1, then vote_A high exactly 1 cycle at 7 cycles after btn_A first sampled, voters_served=1, FSM back to IDLE. Pressing btn_A again -> no pulse.
- Issue, then btn_A and btn_C rise in the same cycle -> invalid pulse once, no vote. Release both, then press btn_C -> vote_C once, voters_served=1.
- 3-cycle glitch on btn_B while ARMED -> no vote. btn_A held before issue -> no vote until it is released and pressed again.
- Cast 260 valid ballots with VOTER_W=8 -> voters_served saturates at 255. Assert reset in CAST-adjacent cycles -> no pulse after reset.
- With BALLOT_TIMEOUT_EN, TIMEOUT_CYCLES=64: issue and no press -> timeout pulse at cycle 64, ready drops, next press ignored. Without the macro -> ready remains 1 past 200 cycles.
